// File: rtl/iir_pkg.sv
// Shared types and constants for the multi-channel biquad.
// State enum, accumulator guard bits, channel-ID width helper.
package iir_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      QUANT,
      OUT
   } state_t;

   localparam int ACC_GUARD = 3;

   localparam logic [2:0] MAC_LAST = 3'd4;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iir_biquad_mc_axis_mac_unit.sv
// Registered signed multiplier feeding a clearable accumulator.
// Ports: clk, rst_n, i_clr, i_en, i_a, i_b -> o_acc (acc incl. pending product).
module iir_mac_unit
   import iir_pkg::*;
#(
   parameter int A_W   = 16,
   parameter int B_W   = 17,
   parameter int ACC_W = 36
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clr,
   input  logic                    i_en,
   input  logic signed [A_W-1:0]   i_a,
   input  logic signed [B_W-1:0]   i_b,
   output logic signed [ACC_W-1:0] o_acc
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0]   r_prod;
   logic                    r_pv;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_ext;

   assign w_ext = $signed({{(ACC_W-P_W){r_prod[P_W-1]}}, r_prod});

   // Fold in the product still sitting in the pipeline register so the
   // final sum is visible the cycle after the last operand is issued.
   assign o_acc = r_pv ? (r_acc + w_ext) : r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
         r_pv   <= 1'b0;
         r_acc  <= '0;
      end else if (i_clr) begin
         r_pv  <= 1'b0;
         r_acc <= '0;
      end else begin
         if (r_pv) r_acc <= r_acc + w_ext;
         r_pv <= i_en;
         if (i_en) r_prod <= P_W'(i_a) * P_W'(i_b);
      end
   end

endmodule

// File: rtl/iir_biquad_mc_axis.sv
// Time-multiplexed DF-I biquad, per-channel state, AXI-Stream in/out.
// Ports: clk, rst_n, s_axis_{tdata,tid,tvalid,tready}, m_axis_{tdata,tid,tvalid,tready}.
// Option: IIR_SAT_EN clamps the result instead of wrapping.
module iir_biquad_mc_axis
   import iir_pkg::*;
#(
   parameter  int coeff_width  = 16,
   parameter  int inout_width  = 16,
   parameter  int scale_factor = 14,
   parameter  int num_ch       = 2,
   parameter  int b0_int_coeff = 2962,
   parameter  int b1_int_coeff = 5615,
   parameter  int b2_int_coeff = 2962,
   parameter  int a1_int_coeff = -9362,
   parameter  int a2_int_coeff = 5203,
   localparam int CH_W         = ch_w(num_ch)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic signed [inout_width-1:0] s_axis_tdata,
   input  logic [CH_W-1:0]               s_axis_tid,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic signed [inout_width-1:0] m_axis_tdata,
   output logic [CH_W-1:0]               m_axis_tid,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready
);

   localparam int ACC_W = inout_width + coeff_width + ACC_GUARD;
   localparam int B_W   = coeff_width + 1;

   // One extra bit so negated feedback coefficients always fit.
   localparam logic signed [B_W-1:0] C_B0  = B_W'(b0_int_coeff);
   localparam logic signed [B_W-1:0] C_B1  = B_W'(b1_int_coeff);
   localparam logic signed [B_W-1:0] C_B2  = B_W'(b2_int_coeff);
   localparam logic signed [B_W-1:0] C_NA1 = B_W'(-a1_int_coeff);
   localparam logic signed [B_W-1:0] C_NA2 = B_W'(-a2_int_coeff);
   localparam logic [CH_W:0]         NCH   = (CH_W+1)'(num_ch);

   state_t r_state;
   state_t w_next;

   logic [2:0]                    r_cnt;
   logic signed [inout_width-1:0] r_x;
   logic [CH_W-1:0]               r_tid;
   logic signed [inout_width-1:0] r_odata;
   logic [CH_W-1:0]               r_otid;

   logic signed [inout_width-1:0] r_x1 [num_ch];
   logic signed [inout_width-1:0] r_x2 [num_ch];
   logic signed [inout_width-1:0] r_y1 [num_ch];
   logic signed [inout_width-1:0] r_y2 [num_ch];

   logic                          w_tid_ok;
   logic                          w_accept;
   logic                          w_mac_en;
   logic signed [inout_width-1:0] w_a;
   logic signed [B_W-1:0]         w_b;
   logic signed [ACC_W-1:0]       w_acc;
   logic signed [inout_width-1:0] w_y;

   assign s_axis_tready = (r_state == IDLE);
   assign m_axis_tvalid = (r_state == OUT);
   assign m_axis_tdata  = r_odata;
   assign m_axis_tid    = r_otid;
   assign w_tid_ok      = ({1'b0, s_axis_tid} < NCH);

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_mac_en = 1'b0;
      unique case (r_state)
         IDLE: begin
            // Out-of-range IDs are handshaken but never leave IDLE.
            if (s_axis_tvalid && w_tid_ok) begin
               w_accept = 1'b1;
               w_next   = MAC;
            end
         end
         MAC: begin
            w_mac_en = 1'b1;
            if (r_cnt == MAC_LAST) w_next = QUANT;
         end
         QUANT: w_next = OUT;
         OUT: if (m_axis_tready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_a = r_x;
      w_b = C_B0;
      case (r_cnt)
         3'd1: begin w_a = r_x1[r_tid]; w_b = C_B1;  end
         3'd2: begin w_a = r_x2[r_tid]; w_b = C_B2;  end
         3'd3: begin w_a = r_y1[r_tid]; w_b = C_NA1; end
         3'd4: begin w_a = r_y2[r_tid]; w_b = C_NA2; end
         default: ;
      endcase
   end

   iir_mac_unit #(
      .A_W   (inout_width),
      .B_W   (B_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_accept),
      .i_en  (w_mac_en),
      .i_a   (w_a),
      .i_b   (w_b),
      .o_acc (w_acc)
   );

`ifdef IIR_SAT_EN
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2**(inout_width-1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2**(inout_width-1)));

   logic signed [ACC_W-1:0] w_shift;

   always_comb begin
      w_shift = w_acc >>> scale_factor;
      if (w_shift > Y_MAX)
         w_y = inout_width'(Y_MAX);
      else if (w_shift < Y_MIN)
         w_y = inout_width'(Y_MIN);
      else
         w_y = inout_width'(w_shift);
   end
`else
   assign w_y = inout_width'(w_acc >>> scale_factor);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_x     <= '0;
         r_tid   <= '0;
         r_odata <= '0;
         r_otid  <= '0;
         for (int i = 0; i < num_ch; i++) begin
            r_x1[i] <= '0;
            r_x2[i] <= '0;
            r_y1[i] <= '0;
            r_y2[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_x   <= s_axis_tdata;
            r_tid <= s_axis_tid;
            r_cnt <= '0;
         end
         if (r_state == MAC) r_cnt <= r_cnt + 3'd1;
         if (r_state == QUANT) begin
            r_x2[r_tid] <= r_x1[r_tid];
            r_x1[r_tid] <= r_x;
            r_y2[r_tid] <= r_y1[r_tid];
            r_y1[r_tid] <= w_y;
            r_odata     <= w_y;
            r_otid      <= r_tid;
         end
      end
   end

endmodule

// File: tb/tb_iir_biquad_mc_axis.sv
// Directed bench for iir_biquad_mc_axis (3-channel main DUT, b0-only DUT).
// Expected outputs hand-computed from the DF-I recurrence with floor shift.
module tb_iir_biquad_mc_axis;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic signed [15:0] s_tdata, m_tdata;
   logic [1:0]         s_tid, m_tid;
   logic               s_tvalid, s_tready, m_tvalid, m_tready;

   logic signed [15:0] s2_tdata, m2_tdata;
   logic               s2_tid, m2_tid;
   logic               s2_tvalid, s2_tready, m2_tvalid, m2_tready;

   int n_run  = 0;
   int n_fail = 0;

   localparam int IMP [6] = '{5923, 14614, 12393, 2440, -2542, -2228};
`ifdef IIR_SAT_EN
   localparam int SAT_EXP = 32767;
`else
   localparam int SAT_EXP = -4;
`endif

   iir_biquad_mc_axis #(.num_ch(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tid    (s_tid),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tid    (m_tid),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready)
   );

   iir_biquad_mc_axis #(
      .num_ch(1), .b0_int_coeff(32767), .b1_int_coeff(0),
      .b2_int_coeff(0), .a1_int_coeff(0), .a2_int_coeff(0)
   ) dut_sat (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s2_tdata),
      .s_axis_tid    (s2_tid),
      .s_axis_tvalid (s2_tvalid),
      .s_axis_tready (s2_tready),
      .m_axis_tdata  (m2_tdata),
      .m_axis_tid    (m2_tid),
      .m_axis_tvalid (m2_tvalid),
      .m_axis_tready (m2_tready)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0;
      s2_tvalid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input int d, input int id);
      int n;
      n = 0;
      @(negedge clk);
      while (!s_tready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("send_timeout", 0, 1);
      s_tdata  = 16'(d);
      s_tid    = 2'(id);
      s_tvalid = 1'b1;
      @(posedge clk);
      #1 s_tvalid = 1'b0;
   endtask

   // lat = number of the edge (after the input handshake) that
   // completes the output handshake.
   task automatic get(input string tag, input int e, input int eid,
                      output int lat);
      lat = 1;
      @(negedge clk);
      while (!m_tvalid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 40) begin
         chk({tag, "_timeout"}, 0, 1);
      end else begin
         chk(tag, int'(m_tdata), e);
         chk({tag, "_tid"}, int'(m_tid), eid);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat, n, bad;
      s_tdata = '0; s_tid = '0; s_tvalid = 1'b0; m_tready = 1'b1;
      s2_tdata = '0; s2_tid = 1'b0; s2_tvalid = 1'b0; m2_tready = 1'b1;

      // Reset values on the first cycle after release
      do_reset();
      @(negedge clk);
      chk("rst_mvalid", int'(m_tvalid), 0);
      chk("rst_mdata", int'(m_tdata), 0);
      chk("rst_mtid", int'(m_tid), 0);
      chk("rst_sready", int'(s_tready), 1);

      // Impulse on ch0
      send(32767, 0);
      get("imp0", IMP[0], 0, lat);
      chk("imp_lat", lat, 7);
      for (int k = 1; k < 6; k++) begin
         send(0, 0);
         get($sformatf("imp%0d", k), IMP[k], 0, lat);
      end

      // Interleaved ch0 impulse / ch1 zeros
      do_reset();
      for (int k = 0; k < 6; k++) begin
         send((k == 0) ? 32767 : 0, 0);
         get($sformatf("il_c0_%0d", k), IMP[k], 0, lat);
         send(0, 1);
         get($sformatf("il_c1_%0d", k), 0, 1, lat);
      end

      // Invalid channel ID
      do_reset();
      send(32767, 0);
      get("inv_c0a", 5923, 0, lat);
      send(32767, 2);
      get("inv_c2a", 5923, 2, lat);
      send(1234, 3);
      n = 0;
      repeat (15) begin
         @(negedge clk);
         if (m_tvalid) n++;
      end
      chk("inv_noout", n, 0);
      chk("inv_ready", int'(s_tready), 1);
      send(0, 0);
      get("inv_c0b", 14614, 0, lat);
      send(0, 2);
      get("inv_c2b", 14614, 2, lat);
      send(0, 1);
      get("inv_c1", 0, 1, lat);

      // Backpressure, with a stray ready pulse while MAC runs
      do_reset();
      m_tready = 1'b1;
      send(32767, 0);
      repeat (2) @(negedge clk);
      chk("stray", int'(m_tvalid), 0);
      m_tready = 1'b0;
      n = 0;
      while (!m_tvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", int'(m_tvalid), 1);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (!m_tvalid || m_tdata != 16'sd5923 || s_tready || m_tid != 2'd0)
            bad++;
      end
      chk("bp_hold", bad, 0);
      m_tready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_sready", int'(s_tready), 1);
      chk("bp_mvalid", int'(m_tvalid), 0);
      s_tdata = '0; s_tid = '0; s_tvalid = 1'b1;
      @(posedge clk);
      #1 s_tvalid = 1'b0;
      get("bp_next", 14614, 0, lat);
      chk("bp_lat", lat, 7);

      // Reset in the middle of MAC
      send(10000, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rmac_mvalid", int'(m_tvalid), 0);
      chk("rmac_sready", int'(s_tready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (m_tvalid) n++;
      end
      chk("rmac_noout", n, 0);
      send(32767, 0);
      get("rmac_y0", 5923, 0, lat);
      send(0, 0);
      get("rmac_y1", 14614, 0, lat);

      // Reset while an output is pending
      m_tready = 1'b0;
      send(5, 1);
      n = 0;
      while (!m_tvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rout_pend", int'(m_tvalid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rout_mvalid", int'(m_tvalid), 0);
      chk("rout_mdata", int'(m_tdata), 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_tready = 1'b1;
      send(32767, 0);
      get("rout_y0", 5923, 0, lat);

      // Saturation vs wrap with b0 = 32767 only
      @(negedge clk);
      s2_tdata = 16'sd32767; s2_tid = 1'b0; s2_tvalid = 1'b1;
      @(posedge clk);
      #1 s2_tvalid = 1'b0;
      n = 0;
      while (!m2_tvalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("sat_valid", int'(m2_tvalid), 1);
      chk("sat_data", int'(m2_tdata), SAT_EXP);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
